// File: rtl/seq_detector.sv
// Serial 1,0,1,1 pattern detector with registered match pulse, saturating match counter and bit history.
// Define SEQ_DETECTOR_OVERLAP_EN for overlapping detection; otherwise a completed match is never reused.
module seq_detector (
    input  logic       clk,
    input  logic       R,
    input  logic       din,
    input  logic       en,
    input  logic       clr_cnt,
    output logic       match,
    output logic [7:0] count,
    output logic [7:0] shreg,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       match_q, match_d;
    logic [7:0] count_q, count_d;
    logic [7:0] shreg_q, shreg_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S0: if (en) state_d = din ? S1 : S0;
            S1: if (en) state_d = din ? S1 : S2;
            S2: if (en) state_d = din ? S3 : S0;
            S3: if (en) state_d = din ? S4 : S2;
`ifdef SEQ_DETECTOR_OVERLAP_EN
            S4: if (en) state_d = din ? S1 : S2;
`else
            S4: if (en) state_d = din ? S1 : S0;
`endif
            // Unused encodings recover to S0 regardless of en.
            default: state_d = S0;
        endcase

        // S4 is only ever entered from S3 on an accepted 1.
        match_d = en && din && (state_q == S3);

        count_d = count_q;
        if (clr_cnt)
            count_d = 8'd0;
        else if (match_d && (count_q != 8'hFF))
            count_d = count_q + 8'd1;

        shreg_d = en ? {shreg_q[6:0], din} : shreg_q;
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state_q <= S0;
            match_q <= 1'b0;
            count_q <= 8'd0;
            shreg_q <= 8'd0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
        end
    end

    assign match = match_q;
    assign count = count_q;
    assign shreg = shreg_q;
    assign state = state_q;

endmodule
